fp16_add_seq: RTL and testbench
===============================

FP16_ADD_SEQ -- requirements
Module: fp16_add_seq

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  operand pair a/b/sub presented.
REQ-004 in_ready  out  1  block can accept an operation; high only in IDLE and not in reset.
REQ-005 a  in  16  IEEE-754 binary16 operand A (sign[15], exp[14:10], mant[9:0]).
REQ-006 b  in  16  binary16 operand B.
REQ-007 sub  in  1  0 = A+B, 1 = A-B.
REQ-008 out_valid  out  1  result, inexact and overflow are valid.
REQ-009 out_ready  in  1  consumer accepts the result.
REQ-010 result  out  16  binary16 sum/difference.
REQ-011 inexact  out  1  nonzero bits were discarded by alignment, normalization or packing.
REQ-012 overflow  out  1  result saturated to infinity from finite operands.
REQ-013 busy  out  1  state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ALIGN, OPER, NORM, PACK and DONE.
REQ-015 Handshake: in_valid & in_ready at an edge latches a, b, sub; IDLE->ALIGN.
REQ-016 Effective sign of B SHALL be b[15]^sub.
REQ-017 Exp-0 inputs SHALL be flushed to signed zero; no denormal outputs.
REQ-018 ALIGN, special cases (-> DONE next edge, inexact=0, overflow=0): any NaN or inf-inf of opposite effective signs -> 16'h7E00; one inf -> that inf with its effective sign; both zero -> +0 unless both effective signs negative (-0).
REQ-019 ALIGN, otherwise: order operands by magnitude (exp, then mant) into X>=Y; d = expX-expY; Y significand {1,mant} right-shifted by d into a 14-bit field (11 bits + guard, round, sticky); d>13 -> Y fully into sticky.
REQ-020 OPER (one cycle): equal signs -> 15-bit add; else X-Y; result sign = sign of X.
REQ-021 Exact zero from OPER SHALL give +0 and go to DONE.
REQ-022 NORM: carry out -> shift right 1, sticky-OR the lost bit, exp+1, one cycle; else while hidden bit 0 and exp>1, shift left 1, exp-1, one step per cycle; at most 12 NORM cycles.
REQ-023 PACK: mode is truncation (round toward zero); guard|round|sticky -> inexact=1.
REQ-024 PACK: exp>=31 -> result = signed inf, overflow=1, inexact=1.
REQ-025 PACK: hidden bit still 0 (underflow) -> signed zero, inexact=1.
REQ-026 DONE: out_valid=1; result/inexact/overflow held stable until out_valid & out_ready at an edge, then -> IDLE.
REQ-027 No new operation SHALL be accepted in the DONE->IDLE edge cycle; in_ready rises the cycle after.
REQ-028 Latency, acceptance edge to out_valid: 2 cycles special path; 5 cycles with one NORM cycle; max 16 cycles.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 rst high at an edge SHALL force IDLE from any state, aborting any operation in flight without producing a result.
REQ-031 While rst is high SHALL hold out_valid=0, in_ready=0, busy=0, result=16'h0000, inexact=0, overflow=0.
REQ-032 First cycle after rst low: in_ready=1.

Verification
REQ-033 a=3C00, b=3C00, sub=0 -> result=4000, inexact=0, overflow=0, out_valid 5 cycles after acceptance.
REQ-034 a=3C00, b=3C00, sub=1 -> result=0000 (+0), inexact=0; a=3C00, b=1000, sub=0 -> result=3C00, inexact=1.
REQ-035 a=7BFF, b=7BFF, sub=0 -> result=7C00, overflow=1, inexact=1; a=3C00, b=3BFF, sub=1 -> result=1000, multi-cycle NORM, inexact=0.
REQ-036 a=7E00, b=3C00 -> 7E00; a=7C00, b=7C00, sub=1 -> 7E00; a=7C00, b=C000, sub=0 -> 7C00; all 2-cycle latency.
REQ-037 out_ready=0 for 10 cycles in DONE -> result, out_valid and flags constant, in_ready=0; rst pulse during NORM -> out_valid never asserts, in_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/fp16_add_seq.sv
// ============================================================================
// fp16_add_seq : multi-cycle IEEE-754 binary16 adder/subtractor, round toward zero
// Rev 1.0
// ============================================================================
`default_nettype none

module fp16_add_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        inexact,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    OPER  = 3'd2,
    NORM  = 3'd3,
    PACK  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0] c_QNAN = 16'h7E00;

  state_t      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [13:0] sx_q;
  logic [13:0] sy_q;
  logic        sign_q;
  logic        eff_sub_q;
  logic [5:0]  exp_q;
  logic [14:0] n_q;
  logic [15:0] result_q;
  logic        inexact_q;
  logic        overflow_q;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        busy_q;

  logic [4:0]  w_ea, w_eb, w_ex, w_ey, w_d;
  logic [9:0]  w_ma, w_mb, w_mx, w_my;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_a_ge_b, w_y_zero, w_sx, w_sy;
  logic        w_special;
  logic [15:0] w_special_res;
  logic [13:0] w_y_full, w_y_aligned;
  logic [27:0] w_y_shift;
  logic [14:0] w_sum, w_diff;

  always_comb begin
    w_ea     = a_q[14:10];
    w_eb     = b_q[14:10];
    w_ma     = a_q[9:0];
    w_mb     = b_q[9:0];
    w_a_zero = (w_ea == 5'd0);
    w_b_zero = (w_eb == 5'd0);
    w_a_inf  = (w_ea == 5'h1F) && (w_ma == 10'd0);
    w_b_inf  = (w_eb == 5'h1F) && (w_mb == 10'd0);
    w_a_nan  = (w_ea == 5'h1F) && (w_ma != 10'd0);
    w_b_nan  = (w_eb == 5'h1F) && (w_mb != 10'd0);

    w_special     = 1'b1;
    w_special_res = 16'h0000;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a_q[15] != b_q[15]))) begin
      w_special_res = c_QNAN;
    end else if (w_a_inf) begin
      w_special_res = {a_q[15], 15'h7C00};
    end else if (w_b_inf) begin
      w_special_res = {b_q[15], 15'h7C00};
    end else if (w_a_zero && w_b_zero) begin
      w_special_res = {a_q[15] & b_q[15], 15'h0000};
    end else begin
      w_special = 1'b0;
    end

    // Flushed operands order as magnitude zero regardless of their mantissa bits.
    w_a_ge_b = ((w_a_zero ? 15'd0 : a_q[14:0]) >= (w_b_zero ? 15'd0 : b_q[14:0]));
    w_ex     = w_a_ge_b ? w_ea : w_eb;
    w_ey     = w_a_ge_b ? w_eb : w_ea;
    w_mx     = w_a_ge_b ? w_ma : w_mb;
    w_my     = w_a_ge_b ? w_mb : w_ma;
    w_sx     = w_a_ge_b ? a_q[15] : b_q[15];
    w_sy     = w_a_ge_b ? b_q[15] : a_q[15];
    w_y_zero = w_a_ge_b ? w_b_zero : w_a_zero;

    w_d       = w_ex - w_ey;
    w_y_full  = w_y_zero ? 14'd0 : {1'b1, w_my, 3'b000};
    w_y_shift = {w_y_full, 14'd0} >> w_d;
    if (w_y_zero) begin
      w_y_aligned = 14'd0;
    end else if (w_d > 5'd13) begin
      w_y_aligned = 14'd1;
    end else begin
      w_y_aligned = w_y_shift[27:14] | {13'd0, |w_y_shift[13:0]};
    end

    w_sum  = {1'b0, sx_q} + {1'b0, sy_q};
    w_diff = {1'b0, sx_q} - {1'b0, sy_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 16'h0000;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= {b[15] ^ sub, b[14:0]};
            state_q    <= ALIGN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ALIGN: begin
          if (w_special) begin
            result_q    <= w_special_res;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            sx_q      <= {1'b1, w_mx, 3'b000};
            sy_q      <= w_y_aligned;
            sign_q    <= w_sx;
            eff_sub_q <= w_sx ^ w_sy;
            exp_q     <= {1'b0, w_ex};
            state_q   <= OPER;
          end
        end
        OPER: begin
          n_q <= eff_sub_q ? w_diff : w_sum;
          if (eff_sub_q && (w_diff == 15'd0)) begin
            result_q    <= 16'h0000;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= NORM;
          end
        end
        NORM: begin
          if (n_q[14]) begin
            n_q     <= {1'b0, n_q[14:2], n_q[1] | n_q[0]};
            exp_q   <= exp_q + 6'd1;
            state_q <= PACK;
          end else if (!n_q[13] && (exp_q > 6'd1)) begin
            n_q   <= {n_q[13:0], 1'b0};
            exp_q <= exp_q - 6'd1;
          end else begin
            state_q <= PACK;
          end
        end
        PACK: begin
          // Truncation: any guard/round/sticky bit only marks the result inexact.
          if (exp_q >= 6'd31) begin
            result_q   <= {sign_q, 15'h7C00};
            overflow_q <= 1'b1;
            inexact_q  <= 1'b1;
          end else if (!n_q[13]) begin
            result_q   <= {sign_q, 15'h0000};
            overflow_q <= 1'b0;
            inexact_q  <= 1'b1;
          end else begin
            result_q   <= {sign_q, exp_q[4:0], n_q[12:3]};
            overflow_q <= 1'b0;
            inexact_q  <= |n_q[2:0];
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs read as idle/zero for the whole time reset is held, not just after its first edge.
  assign in_ready  = in_ready_q & ~rst;
  assign busy      = busy_q & ~rst;
  assign out_valid = out_valid_q & ~rst;
  assign result    = rst ? 16'h0000 : result_q;
  assign inexact   = inexact_q & ~rst;
  assign overflow  = overflow_q & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_fp16_add_seq.sv
// ============================================================================
// tb_fp16_add_seq : scoreboard bench for fp16_add_seq with directed vectors
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp16_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        inexact;
  logic        overflow;
  logic        busy;

  fp16_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .inexact   (inexact),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] res;
    logic        inx;
    logic        ovf;
    int          lat;
    time         t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   next_id = 0;
  bit   seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                       input logic [15:0] er, input logic ei, input logic eo,
                       input int el, input bit push);
    int   n;
    exp_t e;
    @(negedge clk);
    a        = ta;
    b        = tb_;
    sub      = ts;
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      e.id  = next_id;
      e.res = er;
      e.inx = ei;
      e.ovf = eo;
      e.lat = el;
      e.t   = $time;
      sb.push_back(e);
    end
    next_id++;
    #1;
    in_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Monitor: compares each new result against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (rst || !out_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e   = sb.pop_front();
        lat = int'(($time - e.t - 5) / 10) + 1;
        chk($sformatf("v%0d_result", e.id), {16'd0, result}, {16'd0, e.res});
        chk($sformatf("v%0d_inexact", e.id), {31'd0, inexact}, {31'd0, e.inx});
        chk($sformatf("v%0d_overflow", e.id), {31'd0, overflow}, {31'd0, e.ovf});
        chk($sformatf("v%0d_latency", e.id), lat, e.lat);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {30'd0, inexact, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 5, 1'b1);
    issue(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0, 3, 1'b1);
    issue(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b1, 1'b0, 5, 1'b1);
    issue(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b1, 5, 1'b1);
    issue(16'h3C00, 16'h3BFF, 1'b1, 16'h1000, 1'b0, 1'b0, 16, 1'b1);
    issue(16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b0, 2, 1'b1);
    issue(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, 1'b0, 2, 1'b1);
    issue(16'h7C00, 16'hC000, 1'b0, 16'h7C00, 1'b0, 1'b0, 2, 1'b1);
    issue(16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 1'b0, 1'b0, 2, 1'b1);
    issue(16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 2, 1'b1);
    issue(16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, 2, 1'b1);
    issue(16'h3C00, 16'hBC00, 1'b0, 16'h0000, 1'b0, 1'b0, 3, 1'b1);
    issue(16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0, 6, 1'b1);
    issue(16'h4000, 16'h3C00, 1'b0, 16'h4200, 1'b0, 1'b0, 5, 1'b1);
    issue(16'h0001, 16'h3C00, 1'b0, 16'h3C00, 1'b0, 1'b0, 5, 1'b1);
    issue(16'h0500, 16'h0400, 1'b1, 16'h0000, 1'b1, 1'b0, 5, 1'b1);
    issue(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 1'b1, 1'b0, 5, 1'b1);
    issue(16'h3C00, 16'h0400, 1'b1, 16'h3BFF, 1'b1, 1'b0, 6, 1'b1);

    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);

    // Back-pressure: result and flags must hold while the consumer stalls.
    out_ready = 1'b0;
    issue(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 5, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", {16'd0, result}, 32'h4000);
      chk("hold_flags", {30'd0, inexact, overflow}, 32'd0);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_busy", {31'd0, busy}, 32'd0);

    // Abort a long normalisation with reset; nothing may come out of it.
    issue(16'h3C00, 16'h3BFF, 1'b1, 16'h1000, 1'b0, 1'b0, 16, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rst_busy", {31'd0, busy}, 32'd0);
    chk("abort_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_rst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_rst_result", {16'd0, result}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_post_busy", {31'd0, busy}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("abort_no_result", cnt, 32'd0);

    issue(16'h4000, 16'h3C00, 1'b0, 16'h4200, 1'b0, 1'b0, 5, 1'b1);
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("final_drain_pending", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
